// File: rtl/microstepper_pkg.sv
// microstepper_pkg: widths and default chopper timing shared by the microstepper stages
package microstepper_pkg;
  localparam int OFF_W = 10;
  localparam int BLANK_W = 8;
  localparam int MINON_W = 8;
  localparam int TRIP_W = 16;
  localparam logic [OFF_W-1:0] DEF_OFFTIME = 10'd810;
  localparam logic [BLANK_W-1:0] DEF_BLANKTIME = 8'd27;
  localparam logic [MINON_W-1:0] DEF_MINON = 8'd54;
endpackage

// File: rtl/chopper_channel_timer.sv
// chopper_channel_timer: off/blank/min-on countdowns, off_done pulse and saturating trip counter for one phase
module chopper_channel_timer #(
  parameter int OFF_W = microstepper_pkg::OFF_W,
  parameter int BLANK_W = microstepper_pkg::BLANK_W,
  parameter int MINON_W = microstepper_pkg::MINON_W,
  parameter int TRIP_W = microstepper_pkg::TRIP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OFF_W-1:0]   config_offtime,
  input  logic [BLANK_W-1:0] config_blanktime,
  input  logic [MINON_W-1:0] config_minon,
  input  logic               en,
  input  logic               starting,
  input  logic               clear_trip_count,
  output logic [OFF_W-1:0]   off_timer,
  output logic [BLANK_W-1:0] blank_timer,
  output logic [MINON_W-1:0] minimum_on_timer,
  output logic               off_done,
  output logic [TRIP_W-1:0]  trip_count
);
  logic accept;
  logic [BLANK_W-1:0] blank_dec;
  logic [MINON_W-1:0] minon_dec;
  always_comb begin
    accept = !starting && en && off_timer == '0;
    blank_dec = (blank_timer != '0) ? blank_timer - 1'b1 : blank_timer;
    minon_dec = (minimum_on_timer != '0) ? minimum_on_timer - 1'b1 : minimum_on_timer;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      off_timer <= '0;
      blank_timer <= '0;
      minimum_on_timer <= '0;
      off_done <= 1'b0;
      trip_count <= '0;
    end else begin
      off_done <= 1'b0;
      if (starting) begin
        off_timer <= '0;
        blank_timer <= config_blanktime;
        minimum_on_timer <= config_minon;
      end else if (accept) begin
        off_timer <= config_offtime;
        blank_timer <= blank_dec;
        minimum_on_timer <= minon_dec;
      end else if (off_timer == OFF_W'(1)) begin
        // end of off period re-arms blanking and the minimum on-time
        off_timer <= '0;
        blank_timer <= config_blanktime;
        minimum_on_timer <= config_minon;
        off_done <= 1'b1;
      end else begin
        off_timer <= (off_timer != '0) ? off_timer - 1'b1 : off_timer;
        blank_timer <= blank_dec;
        minimum_on_timer <= minon_dec;
      end
      trip_count <= clear_trip_count ? '0 :
                    (accept && trip_count != '1) ? trip_count + 1'b1 : trip_count;
    end
  end
endmodule

// File: rtl/microstepper_chopper_timers.sv
// microstepper_chopper_timers: phase A (ch0) and phase B (ch1) chopper timing channels
module microstepper_chopper_timers #(
  parameter int OFF_W = microstepper_pkg::OFF_W,
  parameter int BLANK_W = microstepper_pkg::BLANK_W,
  parameter int MINON_W = microstepper_pkg::MINON_W,
  parameter int TRIP_W = microstepper_pkg::TRIP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OFF_W-1:0]   config_offtime,
  input  logic [BLANK_W-1:0] config_blanktime,
  input  logic [MINON_W-1:0] config_minon,
  input  logic               offtimer_en0,
  input  logic               offtimer_en1,
  input  logic               a_starting,
  input  logic               b_starting,
  input  logic               clear_trip_count,
  output logic [OFF_W-1:0]   off_timer0,
  output logic [OFF_W-1:0]   off_timer1,
  output logic [BLANK_W-1:0] blank_timer0,
  output logic [BLANK_W-1:0] blank_timer1,
  output logic [MINON_W-1:0] minimum_on_timer0,
  output logic [MINON_W-1:0] minimum_on_timer1,
  output logic               off_done0,
  output logic               off_done1,
  output logic [TRIP_W-1:0]  trip_count0,
  output logic [TRIP_W-1:0]  trip_count1
);
  chopper_channel_timer #(.OFF_W(OFF_W), .BLANK_W(BLANK_W), .MINON_W(MINON_W), .TRIP_W(TRIP_W)) u_ch0 (
    .clk(clk), .reset(reset),
    .config_offtime(config_offtime), .config_blanktime(config_blanktime), .config_minon(config_minon),
    .en(offtimer_en0), .starting(a_starting), .clear_trip_count(clear_trip_count),
    .off_timer(off_timer0), .blank_timer(blank_timer0), .minimum_on_timer(minimum_on_timer0),
    .off_done(off_done0), .trip_count(trip_count0)
  );
  chopper_channel_timer #(.OFF_W(OFF_W), .BLANK_W(BLANK_W), .MINON_W(MINON_W), .TRIP_W(TRIP_W)) u_ch1 (
    .clk(clk), .reset(reset),
    .config_offtime(config_offtime), .config_blanktime(config_blanktime), .config_minon(config_minon),
    .en(offtimer_en1), .starting(b_starting), .clear_trip_count(clear_trip_count),
    .off_timer(off_timer1), .blank_timer(blank_timer1), .minimum_on_timer(minimum_on_timer1),
    .off_done(off_done1), .trip_count(trip_count1)
  );
endmodule

// File: tb/tb_microstepper_chopper_timers.sv
// tb_microstepper_chopper_timers: table-driven cycle vectors plus directed corner sequences
module tb_microstepper_chopper_timers;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] config_offtime = 10'd5;
  logic [7:0] config_blanktime = 8'd3;
  logic [7:0] config_minon = 8'd4;
  logic offtimer_en0 = 1'b0, offtimer_en1 = 1'b0, a_starting = 1'b0, b_starting = 1'b0, clear_trip_count = 1'b0;
  logic [9:0] off_timer0, off_timer1;
  logic [7:0] blank_timer0, blank_timer1, minimum_on_timer0, minimum_on_timer1;
  logic off_done0, off_done1;
  logic [15:0] trip_count0, trip_count1;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic r, e0, e1, as_, bs_, cl;
    int o0, o1, b0, b1, m0, m1, d0, d1, t0, t1;
  } vec_t;
  vec_t tv[$];

  microstepper_chopper_timers dut (
    .clk(clk), .reset(reset),
    .config_offtime(config_offtime), .config_blanktime(config_blanktime), .config_minon(config_minon),
    .offtimer_en0(offtimer_en0), .offtimer_en1(offtimer_en1),
    .a_starting(a_starting), .b_starting(b_starting), .clear_trip_count(clear_trip_count),
    .off_timer0(off_timer0), .off_timer1(off_timer1),
    .blank_timer0(blank_timer0), .blank_timer1(blank_timer1),
    .minimum_on_timer0(minimum_on_timer0), .minimum_on_timer1(minimum_on_timer1),
    .off_done0(off_done0), .off_done1(off_done1),
    .trip_count0(trip_count0), .trip_count1(trip_count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, e0, e1, as_, bs_, cl,
                     input int o0, o1, b0, b1, m0, m1, d0, d1, t0, t1);
    vec_t v;
    v.r = r; v.e0 = e0; v.e1 = e1; v.as_ = as_; v.bs_ = bs_; v.cl = cl;
    v.o0 = o0; v.o1 = o1; v.b0 = b0; v.b1 = b1; v.m0 = m0; v.m1 = m1;
    v.d0 = d0; v.d1 = d1; v.t0 = t0; v.t1 = t1;
    tv.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " off_timer0"}, int'(off_timer0), v.o0);
    chk({tag, " off_timer1"}, int'(off_timer1), v.o1);
    chk({tag, " blank_timer0"}, int'(blank_timer0), v.b0);
    chk({tag, " blank_timer1"}, int'(blank_timer1), v.b1);
    chk({tag, " minimum_on_timer0"}, int'(minimum_on_timer0), v.m0);
    chk({tag, " minimum_on_timer1"}, int'(minimum_on_timer1), v.m1);
    chk({tag, " off_done0"}, int'(off_done0), v.d0);
    chk({tag, " off_done1"}, int'(off_done1), v.d1);
    chk({tag, " trip_count0"}, int'(trip_count0), v.t0);
    chk({tag, " trip_count1"}, int'(trip_count1), v.t1);
  endtask

  initial begin
    vec_t z;
    // r e0 e1 as bs cl | off0 off1 bl0 bl1 mn0 mn1 dn0 dn1 tc0 tc1   (offtime=5 blank=3 minon=4)
    add(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 5,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 4,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 3,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 2,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 1,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 0,0,3,0,4,0,1,0,1,0);
    add(0,0,0,0,0,0, 0,0,2,0,3,0,0,0,1,0);
    add(0,0,0,0,0,0, 0,0,1,0,2,0,0,0,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,1,0,0,0,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,0);
    add(0,1,0,0,0,0, 5,0,0,0,0,0,0,0,2,0);
    add(0,1,0,0,0,0, 4,0,0,0,0,0,0,0,2,0);
    add(0,1,0,0,0,0, 3,0,0,0,0,0,0,0,2,0);
    add(0,1,0,0,0,0, 2,0,0,0,0,0,0,0,2,0);
    add(0,1,0,0,0,0, 1,0,0,0,0,0,0,0,2,0);
    add(0,1,0,0,0,0, 0,0,3,0,4,0,1,0,2,0);
    add(0,1,0,0,0,0, 5,0,2,0,3,0,0,0,3,0);
    add(0,0,0,0,0,0, 4,0,1,0,2,0,0,0,3,0);
    add(0,0,0,0,0,0, 3,0,0,0,1,0,0,0,3,0);
    add(0,1,0,1,0,0, 0,0,3,0,4,0,0,0,3,0);
    add(0,0,0,0,0,0, 0,0,2,0,3,0,0,0,3,0);
    add(0,0,1,0,0,0, 0,5,1,0,2,0,0,0,3,1);
    add(0,0,0,0,0,1, 0,4,0,0,1,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,3,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,2,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,3,0,4,0,1,0,0);
    add(0,0,0,0,0,0, 0,0,0,2,0,3,0,0,0,0);
    add(0,0,0,0,1,0, 0,0,0,3,0,4,0,0,0,0);

    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].r; offtimer_en0 = tv[i].e0; offtimer_en1 = tv[i].e1;
      a_starting = tv[i].as_; b_starting = tv[i].bs_; clear_trip_count = tv[i].cl;
      step();
      chk_all($sformatf("vec%0d", i), tv[i]);
    end
    offtimer_en0 = 0; offtimer_en1 = 0; a_starting = 0; b_starting = 0; clear_trip_count = 0;

    // zero offtime on ch1: trip counted, no off period, no reload; ch0 idle
    config_offtime = 10'd0;
    offtimer_en1 = 1;
    step();
    offtimer_en1 = 0;
    chk("zero_off trip_count1", int'(trip_count1), 1);
    chk("zero_off off_timer1", int'(off_timer1), 0);
    chk("zero_off blank_timer1", int'(blank_timer1), 2);
    step();
    chk("zero_off off_done1", int'(off_done1), 0);
    chk("zero_off blank_timer1_no_reload", int'(blank_timer1), 1);
    chk("zero_off off_timer0", int'(off_timer0), 0);
    chk("zero_off trip_count0", int'(trip_count0), 0);

    // saturation with back-to-back zero-length trips
    offtimer_en0 = 1;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat trip_count0_full", int'(trip_count0), 65535);
    step();
    chk("sat trip_count0_hold", int'(trip_count0), 65535);
    chk("sat off_timer0", int'(off_timer0), 0);
    clear_trip_count = 1;
    step();
    chk("sat clear_wins", int'(trip_count0), 0);
    chk("sat clear_ch1", int'(trip_count1), 0);
    clear_trip_count = 0;
    offtimer_en0 = 0;

    // reset mid-countdown on both channels
    config_offtime = 10'd5;
    a_starting = 1; b_starting = 1;
    step();
    a_starting = 0; b_starting = 0; offtimer_en0 = 1; offtimer_en1 = 1;
    step();
    chk("pre_rst off_timer0", int'(off_timer0), 5);
    chk("pre_rst off_timer1", int'(off_timer1), 5);
    chk("pre_rst blank_timer1", int'(blank_timer1), 2);
    chk("pre_rst minimum_on_timer0", int'(minimum_on_timer0), 3);
    chk("pre_rst trip_count1", int'(trip_count1), 1);
    reset = 1;
    step();
    z = '{r:0, e0:0, e1:0, as_:0, bs_:0, cl:0, o0:0, o1:0, b0:0, b1:0, m0:0, m1:0, d0:0, d1:0, t0:0, t1:0};
    chk_all("mid_rst", z);
    reset = 0; offtimer_en0 = 0; offtimer_en1 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/microstepper_chopper_timers.md
Name: microstepper_chopper_timers

Overview:
Per-phase chopper timing stage. It consumes the peak-current trip requests (offtimer_en0/1) and phase-start pulses (a_starting/b_starting) from the microstepper control stage. It produces the off, blank and minimum-on countdowns that the control stage uses for decay selection, trip gating and fault detection. Two identical channels are included: channel 0 is phase A and channel 1 is phase B. Each channel also keeps a saturating trip counter for telemetry.

Parameters:
OFF_W, 10, off-timer width (matches config_offtime and off_timer ports)
BLANK_W, 8, blank-timer width
MINON_W, 8, minimum-on-timer width
TRIP_W, 16, trip-counter width

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
config_offtime  input  OFF_W  off-period load value, in clk ticks
config_blanktime  input  BLANK_W  blanking load value
config_minon  input  MINON_W  minimum-on load value
offtimer_en0  input  1  ch0 trip request (level, qualified by the control stage)
offtimer_en1  input  1  ch1 trip request
a_starting  input  1  ch0 phase-start pulse
b_starting  input  1  ch1 phase-start pulse
clear_trip_count  input  1  synchronous clear of both trip counters
off_timer0  output  OFF_W  ch0 off countdown
off_timer1  output  OFF_W  ch1 off countdown
blank_timer0  output  BLANK_W  ch0 blank countdown
blank_timer1  output  BLANK_W  ch1 blank countdown
minimum_on_timer0  output  MINON_W  ch0 min-on countdown
minimum_on_timer1  output  MINON_W  ch1 min-on countdown
off_done0  output  1  ch0 one-cycle pulse at end of off period
off_done1  output  1  ch1 one-cycle pulse at end of off period
trip_count0  output  TRIP_W  ch0 accepted trips
trip_count1  output  TRIP_W  ch1 accepted trips

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset has priority over all other inputs, including mid-countdown.
- Per channel, evaluated each clk in this priority order:
  1. Phase start (starting=1):
     - off timer forced to 0
     - blank timer loads config_blanktime
     - min-on timer loads config_minon
     - off_done stays 0
     - no trip is counted, even if en is high in the same cycle
  2. Trip accept (en=1 and off==0):
     - off timer loads config_offtime
     - trip counter increments
     - blank and min-on timers keep counting down
  3. Otherwise, each nonzero timer decrements by 1. Zero timers hold.
- End of off period: when off goes 1->0 by decrement, in that same edge:
  - blank timer loads config_blanktime
  - min-on timer loads config_minon
  - off_done is high for exactly that one cycle
- Latency from en to off_timer = config_offtime is 1 cycle. Off time spans config_offtime cycles with off>0.
- en while off>0 is ignored: no reload, no count.
- config_offtime=0: the trip is accepted and counted, off stays 0, and no off_done or blank reload follows.
- config_blanktime=0 or config_minon=0: the load writes 0, so the timer is effectively disabled.
- Config changes take effect only at the next load. Running countdowns are unaffected.
- Trip counter:
  - saturates at all-ones with no wrap
  - clear_trip_count zeroes both counters and wins over a simultaneous increment
- No underflow is possible: every decrement is guarded by !=0.
- Channels are fully independent. Only the config inputs and clear_trip_count are shared.

Decomposition:
- Shared package microstepper_pkg holds the width constants OFF_W, BLANK_W, MINON_W, TRIP_W. The default config values live there too: offtime 810, blanktime 27, minon 54 (fastdecay threshold 706 stays with the control stage).
- Sub-module chopper_channel_timer holds one channel (three countdowns, off_done, trip counter). The top instantiates it twice.

Test Plan:
- Basic off period, sequence:
  - stimulus: reset 1 then 0; offtime=5, blank=3, minon=4; en0 pulsed for 1 cycle
  - off_timer0 reads 5,4,3,2,1,0 on successive cycles
  - at 0: off_done0 pulses once, blank_timer0=3 and minimum_on_timer0=4, then both count down to 0
  - trip_count0=1
- Retrigger ignored:
  - stimulus: en0 held high for 10 cycles with offtime=5
  - exactly one off period occurs while off>0
  - a second load happens on the first en0 cycle after off==0
  - trip_count0 counts each accepted load only
- Phase start mid-off:
  - stimulus: off_timer0=3; a_starting and en0 both high for 1 cycle
  - next cycle: off_timer0=0, blank_timer0=config_blanktime, minimum_on_timer0=config_minon
  - no off_done0 pulse; trip_count0 unchanged
- Channel independence and zero config:
  - stimulus: offtime=0, en1 pulsed
  - trip_count1 increments; off_timer1 stays 0; no off_done1; channel 0 untouched
- Saturation and clear:
  - stimulus: trip_count0 preloaded by 65535 accepted trips (offtime=0), one more trip
  - trip_count0 holds at 65535
  - clear_trip_count together with a trip in the same cycle -> 0
- Reset mid-operation:
  - stimulus: reset asserted while off/blank/minon are nonzero on both channels
  - next cycle every output is 0
